// File: rtl/i2c_arb_pkg.sv
// Package for the I2C request arbiter.
// Holds the arbiter FSM state encoding, the transaction phase encoding and
// the I2C field widths shared by the arbiter top and its round-robin picker.
package i2c_arb_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_GAP     = 3'd4,
    ST_FINISH  = 3'd5
  } arb_state_e;

  // PH_WRITE: single register write.
  // PH_PTR:   first half of a read, writes the register pointer only.
  // PH_READ:  second half of a read, fetches the register value.
  typedef enum logic [1:0] {
    PH_WRITE = 2'd0,
    PH_PTR   = 2'd1,
    PH_READ  = 2'd2
  } arb_phase_e;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker.
// Scans req starting at index ptr, wrapping modulo NUM_REQ, and returns the
// first requester found.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  IDX_W    index with highest priority this round
//   gnt   out NUM_REQ  one-hot winner (all zero when nothing requests)
//   idx   out IDX_W    binary index of the winner
//   found out 1        any request present
module i2c_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  int j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/i2c_request_arbiter.sv
// Shares one i2c_controller between NUM_REQ on-chip requesters.
// Arbitrates round-robin, drives the controller execute/busy handshake and
// splits every register read into a pointer write followed by a value read.
//
// Optional feature macro: I2C_ARB_TIMEOUT_EN
//   defined   - each busy wait is bounded by TIMEOUT_CYCLES; on expiry the
//               transaction is aborted with done_o and error_o together.
//   undefined - waits are unbounded and error_o is tied to 0.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i / req_rw_i       request and direction (1 = read) per requester
//   req_addr_i             7-bit target address per requester, slice [7i+6:7i]
//   req_reg_i, req_wdata_i register id and write value per requester
//   grant_o                one-hot owner, high from launch through done cycle
//   done_o, error_o        one-cycle completion / abort pulses
//   rdata_o                last read value, held until the next read completes
//   address_o .. execute_o command fields to the controller
//   busy_i, register_value_i status and read data from the controller
//
// Controller handshake: execute_o is raised to request a transaction and
// held until busy_i is sampled high (the controller has accepted it); it is
// then dropped and the transaction is complete once busy_i is sampled low.
// A new transaction is never launched while busy_i is still high.
module i2c_request_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            req_rw_i,
  input  logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*I2C_DATA_W-1:0] req_reg_i,
  input  logic [NUM_REQ*I2C_DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [NUM_REQ-1:0]            error_o,
  output logic [I2C_DATA_W-1:0]         rdata_o,
  output logic [I2C_ADDR_W-1:0]         address_o,
  output logic                          rw_o,
  output logic [I2C_DATA_W-1:0]         register_id_o,
  output logic [I2C_DATA_W-1:0]         register_value_o,
  output logic                          send_register_value_o,
  output logic                          execute_o,
  input  logic                          busy_i,
  input  logic [I2C_DATA_W-1:0]         register_value_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e             state_q, state_d;
  arb_phase_e             phase_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       owner_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic                   exec_q;
  logic [I2C_ADDR_W-1:0]  addr_q;
  logic [I2C_DATA_W-1:0]  reg_q;
  logic [I2C_DATA_W-1:0]  wdata_q;
  logic [I2C_DATA_W-1:0]  rdata_q;

  logic [NUM_REQ-1:0]     pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;

  logic [I2C_ADDR_W-1:0]  sel_addr;
  logic [I2C_DATA_W-1:0]  sel_reg;
  logic [I2C_DATA_W-1:0]  sel_wdata;
  int                     sel;

  logic                   launch;
  logic                   relaunch;
  logic                   timeout_hit;
  logic                   abort;

  i2c_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_i),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Fields of the requester that would win if we launched this cycle.
  always_comb begin
    sel       = int'(pick_idx);
    sel_addr  = req_addr_i[sel*I2C_ADDR_W +: I2C_ADDR_W];
    sel_reg   = req_reg_i[sel*I2C_DATA_W +: I2C_DATA_W];
    sel_wdata = req_wdata_i[sel*I2C_DATA_W +: I2C_DATA_W];
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    relaunch = 1'b0;
    abort    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found && !busy_i) begin
          launch  = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT_HI;
      ST_WAIT_HI: begin
        // An observed busy edge always wins over an expiring timeout.
        if (busy_i) begin
          state_d = ST_WAIT_LO;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_WAIT_LO: begin
        if (!busy_i) begin
          state_d = (phase_q == PH_PTR) ? ST_GAP : ST_FINISH;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_GAP: begin
        relaunch = 1'b1;
        state_d  = ST_LAUNCH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= PH_WRITE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      exec_q  <= 1'b0;
      addr_q  <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (launch) begin
        grant_q <= pick_gnt;
        owner_q <= pick_idx;
        addr_q  <= sel_addr;
        reg_q   <= sel_reg;
        wdata_q <= sel_wdata;
        phase_q <= req_rw_i[pick_idx] ? PH_PTR : PH_WRITE;
        exec_q  <= 1'b1;
      end
      if (relaunch) begin
        phase_q <= PH_READ;
        exec_q  <= 1'b1;
      end
      if (state_q == ST_WAIT_HI && busy_i) exec_q <= 1'b0;
      if (abort) exec_q <= 1'b0;
      if (state_q == ST_WAIT_LO && !busy_i && phase_q == PH_READ) begin
        rdata_q <= register_value_i;
      end
      if (state_q == ST_FINISH) begin
        grant_q <= '0;
        ptr_q   <= (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
      end
    end
  end

  // ---------------------------------------------------- optional timeout
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             wait_entry;

  assign wait_entry = (state_d == ST_WAIT_HI || state_d == ST_WAIT_LO) &&
                      (state_d != state_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (wait_entry) cnt_q <= '0;
      else if (state_q == ST_WAIT_HI || state_q == ST_WAIT_LO) cnt_q <= cnt_q + CNT_W'(1);
      if (abort) err_q <= 1'b1;
      else if (state_q == ST_FINISH) err_q <= 1'b0;
    end
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign error_o     = (state_q == ST_FINISH && err_q) ? grant_q : '0;
`else
  assign timeout_hit = 1'b0;
  assign error_o     = '0;
`endif

  // -------------------------------------------------------------- outputs
  assign grant_o               = grant_q;
  assign done_o                = (state_q == ST_FINISH) ? grant_q : '0;
  assign rdata_o               = rdata_q;
  assign address_o             = addr_q;
  assign register_id_o         = reg_q;
  assign register_value_o      = wdata_q;
  assign execute_o             = exec_q;
  // Direction strobes are only meaningful while someone owns the bus.
  assign rw_o                  = (|grant_q) && (phase_q == PH_READ);
  assign send_register_value_o = (|grant_q) && (phase_q == PH_WRITE);

endmodule
